hc4_prog_loader: RTL and testbench

//   Upstream stage of the hc4 core: owns the 2^ADDR_W x 8 program memory the core fetches from.

---
 rtl/hc4_prog_loader.sv | 196 +++++++++++++++++++
 tb/tb_hc4_prog_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hc4_prog_loader.sv
// hc4_prog_loader
//   Upstream stage of the hc4 core. It owns the 2**ADDR_W x 8 program memory
//   the core fetches from. It accepts a framed byte stream on a valid/ready
//   port: sync byte, length high, length low, then len+1 payload bytes, and
//   optionally a checksum byte. The payload is written from address 0 upward.
//   The core is held in reset while a frame loads, and is released once the
//   frame is complete (and, when checked, verified).
//
//   Optional feature macro: HC4_LOADER_CKSUM_EN
//     defined   : the frame ends with a mod-256 payload checksum byte. A mismatch
//                 enters ERROR, and the core stays in reset.
//     undefined : there is no checksum stage. RUN follows the last payload
//                 byte, and error stays 0.
//
// Ports
//   clk         in   1       system clock
//   nReset      in   1       asynchronous active-low reset
//   rx_data     in   8       stream byte
//   rx_valid    in   1       rx_data valid (accepted when rx_valid & rx_ready)
//   rx_ready    out  1       loader can accept a byte (1 from first clk after reset)
//   cpu_pc      in   ADDR_W  core fetch address
//   cpu_instr   out  8       mem[cpu_pc], combinational
//   cpu_nreset  out  1       active-low reset to the core
//   busy        out  1       frame in progress (LEN_HI..CKSUM)
//   error       out  1       sticky frame error, cleared by the next sync byte
//
// The LEN_HI slice requires 9 <= ADDR_W <= 16.

module hc4_prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter bit          BOOT_RUN  = 1'b0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [7:0]        cpu_instr,
  output logic              cpu_nreset,
  output logic              busy,
  output logic              error
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
`ifdef HC4_LOADER_CKSUM_EN
    ST_CKSUM,
    ST_ERROR,
`endif
    ST_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
`ifdef HC4_LOADER_CKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  logic              rx_ready_q;
  logic              cpu_nreset_q, cpu_nreset_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic              accept;
  logic              mem_we;

  logic [7:0]        mem [DEPTH];

  assign accept     = rx_valid & rx_ready_q;
  assign rx_ready   = rx_ready_q;
  assign cpu_nreset = cpu_nreset_q;
  assign busy       = busy_q;
  assign error      = error_q;

  // Asynchronous read. A same-cycle write to the same address shows up only
  // after the edge, so the core sees the old byte in that cycle.
  assign cpu_instr  = mem[cpu_pc];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      if (BOOT_RUN) state_q <= ST_RUN;
      else          state_q <= ST_IDLE;
      len_q        <= '0;
      wr_addr_q    <= '0;
`ifdef HC4_LOADER_CKSUM_EN
      sum_q        <= '0;
`endif
      rx_ready_q   <= 1'b0;
      cpu_nreset_q <= BOOT_RUN;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_addr_q    <= wr_addr_d;
`ifdef HC4_LOADER_CKSUM_EN
      sum_q        <= sum_d;
`endif
      rx_ready_q   <= 1'b1;
      cpu_nreset_q <= cpu_nreset_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  // Program memory is deliberately not reset: a reset mid-frame keeps
  // whatever bytes were already written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= rx_data;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_addr_d = wr_addr_q;
`ifdef HC4_LOADER_CKSUM_EN
    sum_d     = sum_q;
`endif
    mem_we    = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          // Length bits above ADDR_W are ignored.
          len_d[ADDR_W-1:8] = rx_data[ADDR_W-9:0];
          state_d           = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d[7:0] = rx_data;
          wr_addr_d  = '0;
`ifdef HC4_LOADER_CKSUM_EN
          sum_d      = '0;
`endif
          state_d    = ST_DATA;
        end
        ST_DATA: begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
`ifdef HC4_LOADER_CKSUM_EN
          sum_d     = sum_q + rx_data;
`endif
          // Frame carries len+1 bytes. Ending on wr_addr==len means the
          // address never wraps, even for an all-ones length.
          if (wr_addr_q == len_q) begin
`ifdef HC4_LOADER_CKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_RUN;
`endif
          end
        end
`ifdef HC4_LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (rx_data == sum_q) state_d = ST_RUN;
          else                  state_d = ST_ERROR;
        end
        ST_ERROR: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
        end
`endif
        ST_RUN: begin
          if (rx_data == SYNC_BYTE) state_d = ST_LEN_HI;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered status outputs are derived from the next state, so that they
  // track the state register. The exception is cpu_nreset: it needs RUN in
  // both the current and next state. That makes it rise one edge after RUN
  // entry, and fall on the very edge that accepts a sync byte in RUN.
  always_comb begin
    busy_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
             (state_d == ST_DATA)
`ifdef HC4_LOADER_CKSUM_EN
             || (state_d == ST_CKSUM)
`endif
             ;
    cpu_nreset_d = (state_q == ST_RUN) && (state_d == ST_RUN);
`ifdef HC4_LOADER_CKSUM_EN
    error_d = (state_d == ST_ERROR);
`else
    error_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_hc4_prog_loader.sv
module tb_hc4_prog_loader;

  localparam int unsigned ADDR_W = 12;

  logic              clk = 1'b0;
  logic              nReset;
  logic [7:0]        rx_data, br_data;
  logic              rx_valid, br_valid;
  logic              rx_ready, br_ready;
  logic [ADDR_W-1:0] cpu_pc, br_pc;
  logic [7:0]        cpu_instr, br_instr;
  logic              cpu_nreset, br_nreset;
  logic              busy, br_busy;
  logic              error, br_error;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  hc4_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .nReset(nReset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_nreset(cpu_nreset), .busy(busy), .error(error)
  );

  hc4_prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .BOOT_RUN(1'b1)) dut_br (
    .clk(clk), .nReset(nReset), .rx_data(br_data), .rx_valid(br_valid),
    .rx_ready(br_ready), .cpu_pc(br_pc), .cpu_instr(br_instr),
    .cpu_nreset(br_nreset), .busy(br_busy), .error(br_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for one cycle; returns 1 time unit after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit br);
    if (br) begin br_data = b; br_valid = 1'b1; end
    else    begin rx_data = b; rx_valid = 1'b1; end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    br_valid = 1'b0;
  endtask

  // Checksum byte is only part of the frame in the checked build.
  task automatic send_ck(input logic [7:0] ck, input bit br);
`ifdef HC4_LOADER_CKSUM_EN
    send_byte(ck, br);
`else
    if (ck === 8'hxx) send_byte(ck, br);
`endif
  endtask

  task automatic peek(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
    cpu_pc = a;
    #1;
    check(tag, cpu_instr, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    nReset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; br_data = 8'h00; br_valid = 1'b0;
    cpu_pc = '0; br_pc = '0;

    // Reset state
    #12;
    check("rst_rx_ready",   rx_ready,   1'b0);
    check("rst_cpu_nreset", cpu_nreset, 1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_error",      error,      1'b0);
    check("rst_br_nreset",  br_nreset,  1'b1);
    nReset = 1'b1;
    tick;
    check("rx_ready_up",    rx_ready,   1'b1);
    check("br_nreset_run",  br_nreset,  1'b1);
    check("idle_nreset",    cpu_nreset, 1'b0);

    // Junk before sync is dropped in IDLE
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    check("junk_busy", busy, 1'b0);

    // Basic frame: 3 bytes
    send_byte(8'hA5, 0);
    check("t1_busy_sync", busy, 1'b1);
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    send_ck(8'h66, 0);
    check("t1_busy_end",   busy,       1'b0);
    check("t1_nreset_lag", cpu_nreset, 1'b0);
    tick;
    check("t1_nreset_run", cpu_nreset, 1'b1);
    peek(12'd1, 8'h22, "t1_mem1");
    peek(12'd0, 8'h11, "t1_mem0");
    peek(12'd2, 8'h33, "t1_mem2");

    // Junk in RUN is dropped
    send_byte(8'h00, 0); send_byte(8'hFF, 0); send_byte(8'h5A, 0);
    check("run_junk_nreset", cpu_nreset, 1'b1);
    check("run_junk_busy",   busy,       1'b0);

    // Payload containing the sync byte is stored as data
    send_byte(8'hA5, 0);
    check("t3_nreset_drop", cpu_nreset, 1'b0);
    check("t3_busy",        busy,       1'b1);
    send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'hA5, 0); send_byte(8'h02, 0);
    check("t3_busy_end", busy, 1'b0);
    send_ck(8'h4D, 0);
    tick;
    check("t3_nreset", cpu_nreset, 1'b1);
    peek(12'd0, 8'hA5, "t3_mem0");
    peek(12'd1, 8'h01, "t3_mem1");
    peek(12'd2, 8'hA5, "t3_mem2");
    peek(12'd3, 8'h02, "t3_mem3");

`ifdef HC4_LOADER_CKSUM_EN
    // Bad checksum, then recovery
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'h00, 0);
    check("t2_error",  error,      1'b1);
    check("t2_busy",   busy,       1'b0);
    tick;
    check("t2_nreset", cpu_nreset, 1'b0);
    send_byte(8'h33, 0);
    check("t2_err_sticky", error, 1'b1);
    send_byte(8'hA5, 0);
    check("t2_err_clear", error, 1'b0);
    check("t2_busy_sync", busy,  1'b1);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h5C, 0); send_byte(8'h5C, 0);
    check("t2_ok_error", error, 1'b0);
    tick;
    check("t2_ok_nreset", cpu_nreset, 1'b1);
    peek(12'd0, 8'h5C, "t2_mem0");
    // Restore the t3 byte at address 0 for the checks below
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hA5, 0); send_byte(8'hA5, 0);
    tick;
`else
    check("nock_error", error, 1'b0);
`endif

    // Reset asserted mid-frame after 2 of 4 data bytes
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0);
    check("t4_busy_mid", busy, 1'b1);
    #2 nReset = 1'b0;
    #1;
    check("t4_rst_busy",     busy,       1'b0);
    check("t4_rst_nreset",   cpu_nreset, 1'b0);
    check("t4_rst_rx_ready", rx_ready,   1'b0);
    nReset = 1'b1;
    tick;
    peek(12'd0, 8'hDE, "t4_mem0");
    peek(12'd1, 8'hAD, "t4_mem1");
    peek(12'd2, 8'hA5, "t4_mem2_old");
    send_byte(8'h00, 0);
    check("t4_idle_busy", busy, 1'b0);

    // Full-size frame: 4096 bytes of addr[7:0]; sum mod 256 is 00
    send_byte(8'hA5, 0); send_byte(8'h0F, 0); send_byte(8'hFF, 0);
    for (int i = 0; i < 4096; i++) begin
      logic [11:0] a;
      a = 12'(i);
      send_byte(a[7:0], 0);
    end
    check("t5_busy_end", busy, 1'b0);
    send_ck(8'h00, 0);
    tick;
    check("t5_nreset", cpu_nreset, 1'b1);
    peek(12'd4095, 8'hFF, "t5_mem_last");
    peek(12'd0,    8'h00, "t5_mem0_nowrap");
    peek(12'h123,  8'h23, "t5_mem123");

    // len=0 frame (upper LEN_HI bits ignored) writes exactly mem[0]
    send_byte(8'hA5, 0); send_byte(8'hF0, 0); send_byte(8'h00, 0); send_byte(8'h42, 0);
    check("t5_len0_busy", busy, 1'b0);
    send_ck(8'h42, 0);
    tick;
    check("t5_len0_nreset", cpu_nreset, 1'b1);
    peek(12'd0, 8'h42, "t5_len0_mem0");
    peek(12'd1, 8'h01, "t5_len0_mem1");

    // BOOT_RUN instance: reload while running
    check("t6_br_nreset_pre", br_nreset, 1'b1);
    send_byte(8'hA5, 1);
    check("t6_br_nreset_drop", br_nreset, 1'b0);
    check("t6_br_busy",        br_busy,   1'b1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h77, 1);
    check("t6_br_busy_end", br_busy, 1'b0);
    send_ck(8'h77, 1);
    check("t6_br_nreset_lag", br_nreset, 1'b0);
    tick;
    check("t6_br_nreset_run", br_nreset, 1'b1);
    br_pc = '0;
    #1;
    check("t6_br_mem0", br_instr, 8'h77);
    check("t6_br_error", br_error, 1'b0);
    check("t6_br_ready", br_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
